// File: rtl/fec_pkg.sv
// Shared types and constants for the FEC readout controller: FSM encodings,
// output word-type nibbles and field widths.
package fec_pkg;

   typedef enum logic {
      T_IDLE    = 1'b0,
      T_WAIT_L1 = 1'b1
   } trig_state_t;

   typedef enum logic [2:0] {
      R_IDLE = 3'd0,
      R_HDR  = 3'd1,
      R_ADDR = 3'd2,
      R_DATA = 3'd3,
      R_TRL  = 3'd4
   } rdo_state_t;

   localparam logic [3:0] WT_HDR  = 4'hA;
   localparam logic [3:0] WT_DATA = 4'hD;
   localparam logic [3:0] WT_TRL  = 4'hE;

   localparam int TAG_W   = 12;
   localparam int ADDR_W  = 6;
   localparam logic [ADDR_W-1:0] LAST_CH = 6'd63;

   function automatic logic [15:0] make_word(input logic [3:0] wtype, input logic [11:0] payload);
      return {wtype, payload};
   endfunction

endpackage

// File: rtl/fec_readout_ctrl_if.sv
// Output stream and ADC sample bus of the readout controller.
interface fec_readout_ctrl_if;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic [5:0]  adc_rd_addr;
   logic [11:0] adc_data;

   modport master (
      output out_valid, out_data, adc_rd_addr,
      input  out_ready, adc_data
   );

   modport slave (
      input  out_valid, out_data, adc_rd_addr,
      output out_ready, adc_data
   );
endinterface

// File: rtl/fec_evt_fifo.sv
// Small event-tag queue: synchronous push/pop/clear, head visible without a pop.
module fec_evt_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (count_reg == CNT_W'(DEPTH));
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
   assign head_data = mem[rd_ptr_reg];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         // simultaneous push and pop leave the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/fec_readout_ctrl.sv
// Front-end readout controller: L0/L1 trigger matching into an event-tag queue
// and a 66-word framed readout (header, 64 ADC samples, trailer) per event.
module fec_readout_ctrl
   import fec_pkg::*;
#(
   parameter int L1_WINDOW = 200,
   parameter int EVT_DEPTH = 4
) (
   input  logic                      dtc_clk,
   input  logic                      rst_n,
   input  logic                      trig_l0,
   input  logic                      trig_l1,
   input  logic                      rdocmd,
   input  logic                      rjectcmd,
   input  logic                      rstcmd,
   fec_readout_ctrl_if.master        bus,
   output logic                      busy,
   output logic [2:0]                evt_pending,
   output logic                      overflow
);
   localparam int WIN_W = $clog2(L1_WINDOW + 1);
   localparam int CNT_W = $clog2(EVT_DEPTH + 1);

   // Reset asserts immediately but releases only on a clock edge.
   logic [1:0] rst_sync_reg;
   logic       rst_int_n;

   always_ff @(posedge dtc_clk or negedge rst_n) begin
      if (!rst_n) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_int_n = rst_sync_reg[1];

   trig_state_t      trig_state_reg;
   logic [WIN_W-1:0] win_cnt_reg;
   logic [TAG_W-1:0] evt_tag_reg;
   logic             overflow_reg;

   rdo_state_t        rdo_state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              out_valid_reg;
   logic [15:0]       out_data_reg;

   logic             l1_accept, fifo_push, fifo_pop, handshake;
   logic             fifo_full, fifo_empty;
   logic [TAG_W-1:0] head_tag;
   logic [CNT_W-1:0] fifo_count;

   assign handshake = out_valid_reg && bus.out_ready;
   assign l1_accept = (trig_state_reg == T_WAIT_L1) && (win_cnt_reg != '0)
                      && trig_l1 && !rjectcmd && !rstcmd;
   assign fifo_push = l1_accept && !fifo_full;
   assign fifo_pop  = (rdo_state_reg == R_TRL) && handshake && !rstcmd;

   fec_evt_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (EVT_DEPTH),
      .CNT_W (CNT_W)
   ) u_evt_fifo (
      .clk       (dtc_clk),
      .rst_n     (rst_int_n),
      .clr       (rstcmd),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (evt_tag_reg),
      .head_data (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge dtc_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         trig_state_reg <= T_IDLE;
         win_cnt_reg    <= '0;
         evt_tag_reg    <= '0;
         overflow_reg   <= 1'b0;
      end else if (rstcmd) begin
         trig_state_reg <= T_IDLE;
         win_cnt_reg    <= '0;
         evt_tag_reg    <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         unique case (trig_state_reg)
            T_IDLE: begin
               if (trig_l0) begin
                  trig_state_reg <= T_WAIT_L1;
                  win_cnt_reg    <= WIN_W'(L1_WINDOW);
               end
            end
            T_WAIT_L1: begin
               if (rjectcmd || win_cnt_reg == '0) begin
                  trig_state_reg <= T_IDLE;
               end else if (trig_l1) begin
                  trig_state_reg <= T_IDLE;
                  // a lost L1 keeps the tag so tags stay contiguous in the queue
                  if (fifo_full) overflow_reg <= 1'b1;
                  else           evt_tag_reg  <= evt_tag_reg + TAG_W'(1);
               end else begin
                  win_cnt_reg <= win_cnt_reg - WIN_W'(1);
               end
            end
            default: trig_state_reg <= T_IDLE;
         endcase
      end
   end

   always_ff @(posedge dtc_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rdo_state_reg <= R_IDLE;
         addr_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (rstcmd) begin
         rdo_state_reg <= R_IDLE;
         addr_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         unique case (rdo_state_reg)
            R_IDLE: begin
               if (rdocmd && !fifo_empty) begin
                  rdo_state_reg <= R_HDR;
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= make_word(WT_HDR, head_tag);
               end
            end
            R_HDR: begin
               if (handshake) begin
                  rdo_state_reg <= R_ADDR;
                  addr_reg      <= '0;
                  out_valid_reg <= 1'b0;
               end
            end
            R_ADDR: begin
               // sample for addr_reg has settled by the end of this cycle
               rdo_state_reg <= R_DATA;
               out_valid_reg <= 1'b1;
               out_data_reg  <= make_word(WT_DATA, bus.adc_data);
            end
            R_DATA: begin
               if (handshake) begin
                  if (addr_reg == LAST_CH) begin
                     rdo_state_reg <= R_TRL;
                     out_data_reg  <= make_word(WT_TRL, head_tag);
                  end else begin
                     rdo_state_reg <= R_ADDR;
                     addr_reg      <= addr_reg + ADDR_W'(1);
                     out_valid_reg <= 1'b0;
                  end
               end
            end
            R_TRL: begin
               if (handshake) begin
                  rdo_state_reg <= R_IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            default: rdo_state_reg <= R_IDLE;
         endcase
      end
   end

   assign bus.out_valid   = out_valid_reg;
   assign bus.out_data    = out_data_reg;
   assign bus.adc_rd_addr = addr_reg;
   assign busy            = (rdo_state_reg != R_IDLE);
   assign evt_pending     = 3'(fifo_count);
   assign overflow        = overflow_reg;
endmodule

// File: tb/tb_fec_readout_ctrl.sv
// Directed bench for fec_readout_ctrl: trigger window, reject, overflow,
// framed readout with back-pressure and rstcmd abort.
module tb_fec_readout_ctrl;
   import fec_pkg::*;

   logic       dtc_clk = 1'b0;
   logic       rst_n;
   logic       trig_l0 = 1'b0, trig_l1 = 1'b0, rdocmd = 1'b0, rjectcmd = 1'b0, rstcmd = 1'b0;
   logic       busy;
   logic [2:0] evt_pending;
   logic       overflow;

   int checks   = 0;
   int failures = 0;
   int nwords;
   int vcount;

   fec_readout_ctrl_if bus ();

   always #5 dtc_clk = ~dtc_clk;

   function automatic logic [11:0] adc_model(input logic [5:0] a);
      return 12'({6'd0, a} * 12'd67 + 12'h1B5);
   endfunction

   assign bus.adc_data = adc_model(bus.adc_rd_addr);

   fec_readout_ctrl #(
      .L1_WINDOW (200),
      .EVT_DEPTH (4)
   ) dut (
      .dtc_clk     (dtc_clk),
      .rst_n       (rst_n),
      .trig_l0     (trig_l0),
      .trig_l1     (trig_l1),
      .rdocmd      (rdocmd),
      .rjectcmd    (rjectcmd),
      .rstcmd      (rstcmd),
      .bus         (bus),
      .busy        (busy),
      .evt_pending (evt_pending),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int idx, input logic [11:0] tag);
      if (idx == 0)  return {4'hA, tag};
      if (idx <= 64) return {4'hD, adc_model(6'(idx - 1))};
      return {4'hE, tag};
   endfunction

   task automatic drive(input logic l0, input logic l1, input logic rdo, input logic rj, input logic rst);
      trig_l0 = l0; trig_l1 = l1; rdocmd = rdo; rjectcmd = rj; rstcmd = rst;
      @(negedge dtc_clk);
      trig_l0 = 1'b0; trig_l1 = 1'b0; rdocmd = 1'b0; rjectcmd = 1'b0; rstcmd = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge dtc_clk);
   endtask

   // trig_l1 is sampled exactly gap edges after trig_l0
   task automatic pair(input int gap, input logic rj);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(gap - 1);
      drive(1'b0, 1'b1, 1'b0, rj, 1'b0);
      $display("pair gap=%0d reject=%0d pending=%0d overflow=%0d", gap, rj, evt_pending, overflow);
   endtask

   task automatic readout(input logic [11:0] tag, input bit rnd, input int max_words, output int n);
      logic [15:0] prev = '0;
      bit          stalled = 0;
      int          idx = 0;
      int          cyc = 0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("busy_after_rdocmd", 32'(busy), 32'd1);
      while (busy && idx < max_words && cyc < 3000) begin
         if (stalled)
            check("stall_hold", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, prev});
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("word%0d", idx), 32'(bus.out_data), 32'(exp_word(idx, tag)));
            idx++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         prev    = bus.out_data;
         @(negedge dtc_clk);
         cyc++;
      end
      if (cyc >= 3000) check("readout_timeout", 32'(cyc), 32'd0);
      bus.out_ready = 1'b1;
      n = idx;
      $display("readout tag=%0d random_ready=%0d words=%0d", tag, rnd, idx);
   endtask

   initial begin
      bus.out_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      wait_cyc(3);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_adc_addr", 32'(bus.adc_rd_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pending", 32'(evt_pending), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      wait_cyc(4);

      // basic event: L1 10 cycles after L0, full readout with no stalls
      pair(10, 1'b0);
      check("pending_one", 32'(evt_pending), 32'd1);
      readout(12'd0, 1'b0, 100, nwords);
      check("basic_words", 32'(nwords), 32'd66);
      wait_cyc(2);
      check("basic_busy_end", 32'(busy), 32'd0);
      check("basic_pending_end", 32'(evt_pending), 32'd0);
      check("basic_valid_end", 32'(bus.out_valid), 32'd0);

      // window edge: 201 cycles lost, 200 cycles accepted
      pair(201, 1'b0);
      wait_cyc(2);
      check("late_l1_no_push", 32'(evt_pending), 32'd0);
      pair(200, 1'b0);
      check("edge_l1_push", 32'(evt_pending), 32'd1);

      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rstcmd_pending", 32'(evt_pending), 32'd0);
      check("rstcmd_busy", 32'(busy), 32'd0);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("idle_l1_ignored", 32'(evt_pending), 32'd0);

      // reject beats a simultaneous L1; tag must not advance
      pair(5, 1'b1);
      check("reject_no_push", 32'(evt_pending), 32'd0);

      // five events into a four-deep queue
      for (int i = 0; i < 5; i++) pair(3, 1'b0);
      check("full_pending", 32'(evt_pending), 32'd4);
      check("full_overflow", 32'(overflow), 32'd1);

      readout(12'd0, 1'b1, 100, nwords);
      check("stall_words", 32'(nwords), 32'd66);
      for (int t = 1; t < 4; t++) begin
         readout(12'(t), 1'b0, 100, nwords);
         check($sformatf("drain_words_tag%0d", t), 32'(nwords), 32'd66);
      end
      wait_cyc(2);
      check("drained_pending", 32'(evt_pending), 32'd0);
      check("overflow_sticky", 32'(overflow), 32'd1);

      // next event carries tag 4; abort it mid-readout
      pair(5, 1'b0);
      readout(12'd4, 1'b0, 31, nwords);
      check("abort_words_before", 32'(nwords), 32'd31);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_pending", 32'(evt_pending), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      vcount = 0;
      for (int i = 0; i < 80; i++) begin
         if (bus.out_valid) vcount++;
         @(negedge dtc_clk);
      end
      check("abort_no_trailer", 32'(vcount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fec_readout_ctrl.md
FEC_READOUT_CTRL -- requirements
Module: fec_readout_ctrl

Interface
REQ-001 Parameter L1_WINDOW, default 200: maximum number of dtc_clk cycles allowed from trig_l0 to trig_l1.
REQ-002 Parameter EVT_DEPTH, default 4: number of event tags held pending readout.
REQ-003 Port dtc_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port trig_l0  in  1  one-cycle L0 pulse from the DTC decoder.
REQ-006 Port trig_l1  in  1  one-cycle L1 pulse.
REQ-007 Port rdocmd  in  1  one-cycle RDOCMD (0xE2) pulse.
REQ-008 Port rjectcmd  in  1  one-cycle RJECTCMD (0xEA) pulse.
REQ-009 Port rstcmd  in  1  one-cycle RSTCMD (0xE8) pulse.
REQ-010 Port adc_rd_addr  out  6  ADC sample channel address, 0..63.
REQ-011 Port adc_data  in  12  sample for adc_rd_addr; valid 1 cycle after the address is driven.
REQ-012 Port out_valid  out  1  output word valid.
REQ-013 Port out_data  out  16  output word.
REQ-014 Port out_ready  in  1  downstream accept.
REQ-015 Port busy  out  1  readout in progress.
REQ-016 Port evt_pending  out  3  number of queued events, 0..EVT_DEPTH.
REQ-017 Port overflow  out  1  sticky flag: an L1 was lost because the queue was full.

Function
REQ-018 Trigger FSM states: T_IDLE, T_WAIT_L1.
REQ-019 T_IDLE + trig_l0 -> T_WAIT_L1; window counter loads L1_WINDOW.
- trig_l1 in T_IDLE is ignored.
REQ-020 T_WAIT_L1 behaviour:
- counter decrements once per cycle.
- trig_l1 while counter > 0 -> push current evt_tag into the event queue, increment the 12-bit evt_tag (wraps 4095 -> 0), go to T_IDLE.
- counter reaches 0 without trig_l1 -> T_IDLE, no push.
- trig_l0 is ignored.
REQ-021 rjectcmd in T_WAIT_L1 -> T_IDLE with no push. If rjectcmd and trig_l1 arrive in the same cycle, reject wins.
REQ-022 trig_l1 accepted while the queue is full -> no push, evt_tag unchanged, overflow set to 1 until reset or rstcmd.
REQ-023 Readout FSM states: R_IDLE, R_HDR, R_ADDR, R_DATA, R_TRL.
REQ-024 R_IDLE + rdocmd + evt_pending > 0 -> R_HDR. rdocmd is ignored when the queue is empty or the readout FSM is not in R_IDLE.
REQ-025 R_HDR drives out_data = {4'hA, head_tag}, out_valid = 1; on handshake -> R_ADDR with adc_rd_addr = 0.
REQ-026 R_ADDR holds the address for one cycle -> R_DATA.
REQ-027 R_DATA behaviour:
- registers {4'hD, adc_data} to out_data with out_valid = 1.
- on handshake: if adc_rd_addr = 63 -> R_TRL; otherwise increment adc_rd_addr and -> R_ADDR.
- minimum 2 cycles per data word.
REQ-028 R_TRL drives {4'hE, head_tag}; on handshake pop the queue -> R_IDLE.
REQ-029 A readout is exactly 66 words: header, 64 data words, trailer.
REQ-030 out_data and out_valid are held stable while out_valid = 1 and out_ready = 0.
REQ-031 A push and a pop in the same cycle both take effect; evt_pending is unchanged.
REQ-032 busy = 1 in every readout state other than R_IDLE.
REQ-033 rstcmd clears all state to reset values on the next edge, has highest priority, and aborts any readout without emitting a trailer.

Reset
REQ-034 rst_n low asynchronously forces:
- both FSMs to idle (T_IDLE, R_IDLE).
- adc_rd_addr = 0, out_valid = 0, out_data = 0.
- busy = 0, evt_pending = 0, overflow = 0.
- evt_tag = 0, window counter = 0, queue empty.
REQ-035 Release of rst_n is synchronised to dtc_clk before it reaches the FSMs.

Structure
REQ-036 Package fec_pkg holds the FSM enum types and word-type constants (HDR = 4'hA, DATA = 4'hD, TRL = 4'hE).
REQ-037 The event queue is a sub-module, fec_evt_fifo: 12-bit wide, EVT_DEPTH deep, with full/empty/count outputs and synchronous push/pop.

Verification
REQ-038 trig_l0, then trig_l1 10 cycles later, then rdocmd, with out_ready = 1 -> expect:
- 66 words: 0xA000, then 0xD000|data for channels 0..63, then 0xE000.
- evt_pending returns to 0.
REQ-039 trig_l0, then trig_l1 at cycle 201 (L1_WINDOW = 200) -> no push; evt_pending = 0.
REQ-040 5 L0/L1 pairs with no readout -> evt_pending = 4, overflow = 1, tags 0..3 queued, next tag 4.
REQ-041 trig_l1 and rjectcmd in the same cycle during T_WAIT_L1 -> no push; evt_tag unchanged.
REQ-042 During readout, toggle out_ready randomly -> no word lost or duplicated; out_data stable while stalled.
REQ-043 rstcmd at data word 30 -> out_valid = 0 and busy = 0 next cycle; evt_pending = 0; no trailer emitted.
